// File: rtl/dmem_arbiter_if.sv
// Requester-side and memory-side signals of the two-port data-memory arbiter.
interface dmem_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned AW     = 9
);
  logic              p0_req;
  logic              p1_req;
  logic              p0_rw;
  logic              p1_rw;
  logic [31:0]       p0_addr;
  logic [31:0]       p1_addr;
  logic [DATA_W-1:0] p0_wdata;
  logic [DATA_W-1:0] p1_wdata;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              p0_rvalid;
  logic              p1_rvalid;
  logic [DATA_W-1:0] p0_rdata;
  logic [DATA_W-1:0] p1_rdata;
  logic              p0_stall;
  logic              err_oob;
  logic              mem_active;
  logic              mem_rw;
  logic [AW-1:0]     mem_index;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    output p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_stall, err_oob,
           mem_active, mem_rw, mem_index, mem_wdata
  );

  // Requesters plus memory side
  modport master (
    output p0_req, p1_req, p0_rw, p1_rw, p0_addr, p1_addr, p0_wdata, p1_wdata, mem_rdata,
    input  p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, p0_rdata, p1_rdata, p0_stall, err_oob,
           mem_active, mem_rw, mem_index, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of a single-ported, level-sensitive data memory.
// Port 0 (pipeline MEM stage) has priority; port 1 wins after STARVE_LIMIT lost rounds.
module dmem_arbiter #(
  parameter int unsigned DEPTH        = 512,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              oob_q, oob_d;
  logic              rw_q, rw_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              mem_active_q, mem_active_d;
  logic              mem_rw_q, mem_rw_d;
  logic [AW-1:0]     mem_index_q, mem_index_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              p0_rvalid_q, p0_rvalid_d;
  logic              p1_rvalid_q, p1_rvalid_d;
  logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
  logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;
  logic              err_oob_q, err_oob_d;

  logic              p0_gnt_c, p1_gnt_c, p0_stall_c;
  logic              gnt_rw, gnt_oob;
  logic [31:0]       gnt_addr;
  logic [DATA_W-1:0] gnt_wdata;

  // Arbitration: grants are combinational from req and state, suppressed while in reset
  always_comb begin
    p0_gnt_c = 1'b0;
    p1_gnt_c = 1'b0;
    if (state_q != ACCESS) begin
      if (bus.p0_req && bus.p1_req) begin
        if (starve_q == SW'(STARVE_LIMIT)) p1_gnt_c = rst_n;
        else                               p0_gnt_c = rst_n;
      end else if (bus.p0_req) begin
        p0_gnt_c = rst_n;
      end else if (bus.p1_req) begin
        p1_gnt_c = rst_n;
      end
    end
    gnt_rw     = p1_gnt_c ? bus.p1_rw    : bus.p0_rw;
    gnt_addr   = p1_gnt_c ? bus.p1_addr  : bus.p0_addr;
    gnt_wdata  = p1_gnt_c ? bus.p1_wdata : bus.p0_wdata;
    gnt_oob    = (gnt_addr >= 32'(DEPTH));
    p0_stall_c = rst_n & ((bus.p0_req & ~p0_gnt_c) | ((state_q == ACCESS) & ~owner_q));
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    oob_d        = oob_q;
    rw_d         = rw_q;
    mem_active_d = 1'b0;
    mem_rw_d     = 1'b1;
    mem_index_d  = mem_index_q;
    mem_wdata_d  = mem_wdata_q;
    p0_rvalid_d  = 1'b0;
    p1_rvalid_d  = 1'b0;
    p0_rdata_d   = p0_rdata_q;
    p1_rdata_d   = p1_rdata_q;
    err_oob_d    = 1'b0;

    // Port 1 starvation counter
    if (!bus.p1_req || p1_gnt_c)                         starve_d = '0;
    else if (p0_gnt_c && starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + SW'(1);
    else                                                 starve_d = starve_q;

    case (state_q)
      ACCESS: begin
        // Capture the memory output on the edge that ends the access
        state_d   = RESP;
        err_oob_d = oob_q;
        if (owner_q) begin
          p1_rvalid_d = 1'b1;
          p1_rdata_d  = (rw_q && !oob_q) ? bus.mem_rdata : '0;
        end else begin
          p0_rvalid_d = 1'b1;
          p0_rdata_d  = (rw_q && !oob_q) ? bus.mem_rdata : '0;
        end
      end
      IDLE, RESP: begin
        if (p0_gnt_c || p1_gnt_c) begin
          state_d      = ACCESS;
          owner_d      = p1_gnt_c;
          oob_d        = gnt_oob;
          rw_d         = gnt_rw;
          mem_active_d = ~gnt_oob;
          mem_rw_d     = gnt_rw;
          mem_index_d  = gnt_addr[AW-1:0];
          mem_wdata_d  = gnt_wdata;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops mem_active immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      oob_q        <= 1'b0;
      rw_q         <= 1'b1;
      starve_q     <= '0;
      mem_active_q <= 1'b0;
      mem_rw_q     <= 1'b1;
      mem_index_q  <= '0;
      mem_wdata_q  <= '0;
      p0_rvalid_q  <= 1'b0;
      p1_rvalid_q  <= 1'b0;
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      err_oob_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      oob_q        <= oob_d;
      rw_q         <= rw_d;
      starve_q     <= starve_d;
      mem_active_q <= mem_active_d;
      mem_rw_q     <= mem_rw_d;
      mem_index_q  <= mem_index_d;
      mem_wdata_q  <= mem_wdata_d;
      p0_rvalid_q  <= p0_rvalid_d;
      p1_rvalid_q  <= p1_rvalid_d;
      p0_rdata_q   <= p0_rdata_d;
      p1_rdata_q   <= p1_rdata_d;
      err_oob_q    <= err_oob_d;
    end
  end

  assign bus.p0_gnt     = p0_gnt_c;
  assign bus.p1_gnt     = p1_gnt_c;
  assign bus.p0_stall   = p0_stall_c;
  assign bus.p0_rvalid  = p0_rvalid_q;
  assign bus.p1_rvalid  = p1_rvalid_q;
  assign bus.p0_rdata   = p0_rdata_q;
  assign bus.p1_rdata   = p1_rdata_q;
  assign bus.err_oob    = err_oob_q;
  assign bus.mem_active = mem_active_q;
  assign bus.mem_rw     = mem_rw_q;
  assign bus.mem_index  = mem_index_q;
  assign bus.mem_wdata  = mem_wdata_q;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural 512x32 level-sensitive memory.
module tb_dmem_arbiter;
  localparam int unsigned DEPTH  = 512;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned AW     = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   n_chk = 0;
  int   n_bad = 0;
  logic [31:0] mem [DEPTH];

  dmem_arbiter_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

  dmem_arbiter #(.DEPTH(DEPTH), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read, write while active with rw=0 at the clock edge
  assign bus.mem_rdata = mem[bus.mem_index];
  always @(posedge clk) if (bus.mem_active && !bus.mem_rw) mem[bus.mem_index] <= bus.mem_wdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here, outputs sampled 1 later
  task automatic next();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = 32'h0;
    for (int i = 0; i < 4; i++) mem[i] = 32'h1000_0000 + 32'(i);
    mem[7] = 32'h1234_5678;
    bus.p0_req = 1'b0; bus.p0_rw = 1'b1; bus.p0_addr = 32'd0; bus.p0_wdata = 32'd0;
    bus.p1_req = 1'b0; bus.p1_rw = 1'b1; bus.p1_addr = 32'd0; bus.p1_wdata = 32'd0;

    // Reset values, with a request pending that must not be granted
    #1 rst_n = 1'b0;
    bus.p0_req = 1'b1;
    #2;
    chk("rst_p0_gnt",     32'(bus.p0_gnt),     32'd0);
    chk("rst_p1_gnt",     32'(bus.p1_gnt),     32'd0);
    chk("rst_p0_rvalid",  32'(bus.p0_rvalid),  32'd0);
    chk("rst_p1_rvalid",  32'(bus.p1_rvalid),  32'd0);
    chk("rst_p0_rdata",   bus.p0_rdata,        32'd0);
    chk("rst_p1_rdata",   bus.p1_rdata,        32'd0);
    chk("rst_err_oob",    32'(bus.err_oob),    32'd0);
    chk("rst_p0_stall",   32'(bus.p0_stall),   32'd0);
    chk("rst_mem_active", 32'(bus.mem_active), 32'd0);
    chk("rst_mem_rw",     32'(bus.mem_rw),     32'd1);
    chk("rst_mem_index",  32'(bus.mem_index),  32'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       32'd0);
    bus.p0_req = 1'b0;
    next();
    rst_n = 1'b1;

    // Idle: memory disabled, nothing granted or returned
    for (int i = 0; i < 4; i++) begin
      next(); #1;
      chk("idle_mem_active", 32'(bus.mem_active), 32'd0);
      chk("idle_mem_rw",     32'(bus.mem_rw),     32'd1);
      chk("idle_gnt",        32'({bus.p0_gnt, bus.p1_gnt}),       32'd0);
      chk("idle_rvalid",     32'({bus.p0_rvalid, bus.p1_rvalid}), 32'd0);
    end

    // p0 write addr 5, then p0 read addr 5 issued in the response cycle
    next();
    bus.p0_req = 1'b1; bus.p0_rw = 1'b0; bus.p0_addr = 32'd5; bus.p0_wdata = 32'hDEAD_BEEF;
    #1;
    chk("wr_p0_gnt",   32'(bus.p0_gnt),   32'd1);
    chk("wr_p1_gnt",   32'(bus.p1_gnt),   32'd0);
    chk("wr_stall_g",  32'(bus.p0_stall), 32'd0);
    chk("wr_pre_act",  32'(bus.mem_active), 32'd0);
    next();
    bus.p0_req = 1'b0;
    #1;
    chk("wr_active",   32'(bus.mem_active), 32'd1);
    chk("wr_mem_rw",   32'(bus.mem_rw),     32'd0);
    chk("wr_index",    32'(bus.mem_index),  32'd5);
    chk("wr_wdata",    bus.mem_wdata,       32'hDEAD_BEEF);
    chk("wr_rvalid_a", 32'(bus.p0_rvalid),  32'd0);
    chk("wr_stall_a",  32'(bus.p0_stall),   32'd1);
    next();
    bus.p0_req = 1'b1; bus.p0_rw = 1'b1; bus.p0_addr = 32'd5;
    #1;
    chk("wr_rvalid",   32'(bus.p0_rvalid),  32'd1);
    chk("wr_err",      32'(bus.err_oob),    32'd0);
    chk("wr_resp_act", 32'(bus.mem_active), 32'd0);
    chk("wr_resp_rw",  32'(bus.mem_rw),     32'd1);
    chk("rd_p0_gnt",   32'(bus.p0_gnt),     32'd1);
    chk("rd_stall_g",  32'(bus.p0_stall),   32'd0);
    next();
    bus.p0_req = 1'b0;
    #1;
    chk("rd_active",   32'(bus.mem_active), 32'd1);
    chk("rd_mem_rw",   32'(bus.mem_rw),     32'd1);
    chk("rd_index",    32'(bus.mem_index),  32'd5);
    next(); #1;
    chk("rd_rvalid",   32'(bus.p0_rvalid),  32'd1);
    chk("rd_rdata",    bus.p0_rdata,        32'hDEAD_BEEF);
    chk("rd_resp_act", 32'(bus.mem_active), 32'd0);
    next(); #1;
    chk("rd_rvalid_off", 32'(bus.p0_rvalid), 32'd0);
    chk("rd_rdata_hold", bus.p0_rdata,       32'hDEAD_BEEF);
    chk("mem5_written",  mem[5],             32'hDEAD_BEEF);

    // p1 read addr 5, then p1 read addr 600 (out of range)
    next();
    bus.p1_req = 1'b1; bus.p1_rw = 1'b1; bus.p1_addr = 32'd5;
    #1;
    chk("p1_gnt_a", 32'(bus.p1_gnt), 32'd1);
    chk("p1_nostall", 32'(bus.p0_stall), 32'd0);
    next();
    bus.p1_req = 1'b0;
    next();
    bus.p1_req = 1'b1; bus.p1_addr = 32'd600;
    #1;
    chk("p1_rvalid_a", 32'(bus.p1_rvalid), 32'd1);
    chk("p1_rdata_a",  bus.p1_rdata,       32'hDEAD_BEEF);
    chk("p1_gnt_oob",  32'(bus.p1_gnt),    32'd1);
    next();
    bus.p1_req = 1'b0;
    #1;
    chk("oob_active", 32'(bus.mem_active), 32'd0);
    next(); #1;
    chk("oob_rvalid", 32'(bus.p1_rvalid), 32'd1);
    chk("oob_rdata",  bus.p1_rdata,       32'd0);
    chk("oob_err",    32'(bus.err_oob),   32'd1);
    chk("oob_p0_rdata_hold", bus.p0_rdata, 32'hDEAD_BEEF);
    next(); #1;
    chk("oob_err_off",    32'(bus.err_oob),   32'd0);
    chk("oob_rvalid_off", 32'(bus.p1_rvalid), 32'd0);

    // Back-to-back p0 reads of addr 0..3 with req held high
    for (int c = 0; c <= 8; c++) begin
      next();
      bus.p0_req  = (c <= 6);
      bus.p0_rw   = 1'b1;
      bus.p0_addr = 32'((c + 1) / 2);
      #1;
      chk("b2b_gnt",    32'(bus.p0_gnt),    ((c % 2 == 0) && c <= 6) ? 32'd1 : 32'd0);
      chk("b2b_rvalid", 32'(bus.p0_rvalid), ((c % 2 == 0) && c >= 2) ? 32'd1 : 32'd0);
      chk("b2b_stall",  32'(bus.p0_stall),  (c % 2 == 1) ? 32'd1 : 32'd0);
      if ((c % 2 == 0) && c >= 2) chk("b2b_rdata", bus.p0_rdata, 32'h1000_0000 + 32'((c - 2) / 2));
    end
    bus.p0_req = 1'b0;

    // Both ports request continuously: p1 wins every fifth grant
    k = 0;
    for (int c = 0; c < 60 && k < 10; c++) begin
      next();
      bus.p0_req = 1'b1; bus.p0_rw = 1'b1; bus.p0_addr = 32'd10;
      bus.p1_req = 1'b1; bus.p1_rw = 1'b1; bus.p1_addr = 32'd20;
      #1;
      if (bus.p0_gnt || bus.p1_gnt) begin
        chk("arb_excl",   32'(bus.p0_gnt & bus.p1_gnt), 32'd0);
        chk("arb_winner", 32'(bus.p1_gnt), (k % 5 == 4) ? 32'd1 : 32'd0);
        k++;
      end
    end
    chk("arb_grant_count", 32'(k), 32'd10);
    bus.p0_req = 1'b0; bus.p1_req = 1'b0;
    next(); next(); next();

    // Reset in the middle of a p1 write to addr 7
    next();
    bus.p1_req = 1'b1; bus.p1_rw = 1'b0; bus.p1_addr = 32'd7; bus.p1_wdata = 32'hBAD0_BAD0;
    #1;
    chk("rw_p1_gnt", 32'(bus.p1_gnt), 32'd1);
    next();
    bus.p1_req = 1'b0;
    #1;
    chk("rw_active", 32'(bus.mem_active), 32'd1);
    chk("rw_index",  32'(bus.mem_index),  32'd7);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_async_active", 32'(bus.mem_active), 32'd0);
    chk("rw_async_rw",     32'(bus.mem_rw),     32'd1);
    next(); #1;
    chk("rw_no_rvalid", 32'(bus.p1_rvalid), 32'd0);
    chk("rw_mem7",      mem[7],             32'h1234_5678);
    rst_n = 1'b1;
    next();
    bus.p0_req = 1'b1; bus.p0_rw = 1'b1; bus.p0_addr = 32'd7;
    #1;
    chk("rw_rd_gnt", 32'(bus.p0_gnt), 32'd1);
    next();
    bus.p0_req = 1'b0;
    next(); #1;
    chk("rw_rd_rvalid", 32'(bus.p0_rvalid), 32'd1);
    chk("rw_rd_rdata",  bus.p0_rdata,       32'h1234_5678);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
